// File: rtl/pll_phase_pkg.sv
// Shared types and encodings for the ECP5 EHXPLLL dynamic phase-adjust sequencer.
package pll_phase_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4,
    ABORT = 3'd5
  } state_t;

  localparam logic [1:0] SEL_CLKOS  = 2'b00;
  localparam logic [1:0] SEL_CLKOS2 = 2'b01;
  localparam logic [1:0] SEL_CLKOS3 = 2'b10;
  localparam logic [1:0] SEL_CLKOP  = 2'b11;

  localparam logic DIR_LAG  = 1'b0;
  localparam logic DIR_LEAD = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Synchronises the asynchronous PLL LOCK and requires LOCK_FILT consecutive high cycles.
// With PLL_PHASE_LOCKLOSS_CNT_EN, also exposes the cycle in which lock_ok is about to fall.
module pll_lock_filter #(
  parameter int LOCK_FILT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
`ifdef PLL_PHASE_LOCKLOSS_CNT_EN
  output logic lock_fall,
`endif
  output logic lock_ok
);

  localparam int CNT_W = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b00;
      cnt     <= '0;
      lock_ok <= 1'b0;
    end else begin
      sync <= {sync[0], pll_locked};
      if (!sync[1]) begin
        cnt     <= '0;
        lock_ok <= 1'b0;
      end else begin
        // Counter saturates at LOCK_FILT-1; the 16th high cycle sets lock_ok.
        if (cnt != CNT_W'(LOCK_FILT - 1)) cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(LOCK_FILT - 1)) lock_ok <= 1'b1;
      end
    end
  end

`ifdef PLL_PHASE_LOCKLOSS_CNT_EN
  assign lock_fall = lock_ok & ~sync[1];
`endif

endmodule

// File: rtl/pll_phase_ctrl.sv
// EHXPLLL phase-step sequencer with lock-qualified system reset.
// Optional lock-loss counter enabled by defining PLL_PHASE_LOCKLOSS_CNT_EN.
module pll_phase_ctrl
  import pll_phase_pkg::*;
#(
  parameter int SETUP_CYC = 4,
  parameter int PULSE_CYC = 4,
  parameter int HOLD_CYC  = 8,
  parameter int LOCK_FILT = 16,
  parameter int STEP_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic              req_dir,
  input  logic [STEP_W-1:0] req_steps,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [1:0]        pll_phasesel,
  output logic              pll_phasedir,
  output logic              pll_phasestep,
  output logic              pll_phaseloadreg,
  output logic              lock_ok,
`ifdef PLL_PHASE_LOCKLOSS_CNT_EN
  output logic [7:0]        lockloss_cnt,
`endif
  output logic              sys_rst_n
);

  localparam int CYC_MAX = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  state_t            state;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [STEP_W-1:0] remaining;

`ifdef PLL_PHASE_LOCKLOSS_CNT_EN
  logic lock_fall;
`endif

  pll_lock_filter #(.LOCK_FILT(LOCK_FILT)) u_lock_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
`ifdef PLL_PHASE_LOCKLOSS_CNT_EN
    .lock_fall  (lock_fall),
`endif
    .lock_ok    (lock_ok)
  );

  assign sys_rst_n        = lock_ok;
  assign pll_phaseloadreg = 1'b0;
  assign req_ready        = (state == IDLE) & lock_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cyc_cnt       <= '0;
      remaining     <= '0;
      pll_phasesel  <= SEL_CLKOS;
      pll_phasedir  <= DIR_LAG;
      pll_phasestep <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            pll_phasesel <= req_sel;
            pll_phasedir <= req_dir;
            remaining    <= req_steps;
            cyc_cnt      <= '0;
            busy         <= 1'b1;
            if (req_steps == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SETUP;
            end
          end
        end
        SETUP, PULSE, HOLD: begin
          if (!lock_ok) begin
            // Lock loss kills the request; a partial pulse is dropped, not finished.
            state         <= ABORT;
            pll_phasestep <= 1'b0;
            aborted       <= 1'b1;
          end else if (state == SETUP) begin
            if (cyc_cnt == CYC_W'(SETUP_CYC - 1)) begin
              state         <= PULSE;
              pll_phasestep <= 1'b1;
              cyc_cnt       <= '0;
            end else begin
              cyc_cnt <= cyc_cnt + CYC_W'(1);
            end
          end else if (state == PULSE) begin
            if (cyc_cnt == CYC_W'(PULSE_CYC - 1)) begin
              state         <= HOLD;
              pll_phasestep <= 1'b0;
              cyc_cnt       <= '0;
            end else begin
              cyc_cnt <= cyc_cnt + CYC_W'(1);
            end
          end else begin
            if (cyc_cnt == CYC_W'(HOLD_CYC - 1)) begin
              cyc_cnt   <= '0;
              remaining <= remaining - STEP_W'(1);
              if (remaining == STEP_W'(1)) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state         <= PULSE;
                pll_phasestep <= 1'b1;
              end
            end else begin
              cyc_cnt <= cyc_cnt + CYC_W'(1);
            end
          end
        end
        DONE, ABORT: begin
          state        <= IDLE;
          busy         <= 1'b0;
          pll_phasesel <= SEL_CLKOS;
          pll_phasedir <= DIR_LAG;
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          pll_phasestep <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_PHASE_LOCKLOSS_CNT_EN
  logic [7:0] lockloss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lockloss_q <= 8'd0;
    end else if (lock_fall && lockloss_q != 8'hFF) begin
      lockloss_q <= lockloss_q + 8'd1;
    end
  end

  assign lockloss_cnt = lockloss_q;
`endif

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: lock filter, step timing, zero-step, lock-loss abort, async reset.
module tb_pll_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic       req_dir;
  logic [7:0] req_steps;
  logic       busy, done, aborted;
  logic [1:0] pll_phasesel;
  logic       pll_phasedir, pll_phasestep, pll_phaseloadreg;
  logic       lock_ok, sys_rst_n;
`ifdef PLL_PHASE_LOCKLOSS_CNT_EN
  logic [7:0] lockloss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_phase_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pll_locked       (pll_locked),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_sel          (req_sel),
    .req_dir          (req_dir),
    .req_steps        (req_steps),
    .busy             (busy),
    .done             (done),
    .aborted          (aborted),
    .pll_phasesel     (pll_phasesel),
    .pll_phasedir     (pll_phasedir),
    .pll_phasestep    (pll_phasestep),
    .pll_phaseloadreg (pll_phaseloadreg),
    .lock_ok          (lock_ok),
`ifdef PLL_PHASE_LOCKLOSS_CNT_EN
    .lockloss_cnt     (lockloss_cnt),
`endif
    .sys_rst_n        (sys_rst_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".step"},   pll_phasestep, 0);
    check({tag, ".sel"},    pll_phasesel, 0);
    check({tag, ".dir"},    pll_phasedir, 0);
    check({tag, ".load"},   pll_phaseloadreg, 0);
    check({tag, ".busy"},   busy, 0);
    check({tag, ".done"},   done, 0);
    check({tag, ".abort"},  aborted, 0);
    check({tag, ".lock"},   lock_ok, 0);
    check({tag, ".sysrst"}, sys_rst_n, 0);
    check({tag, ".ready"},  req_ready, 0);
  endtask

  // Issue a request at the current cycle T and check every cycle T+1..T+ncyc against spec timing.
  task automatic run_req(input string tag, input logic [1:0] sel, input logic dir,
                         input int steps, input int ncyc);
    int  dc;
    int  pulses;
    logic exp_step, prev_step;
    dc = (steps == 0) ? 1 : 5 + 12 * steps;
    pulses = 0;
    prev_step = 1'b0;
    check({tag, ".ready_T"}, req_ready, 1);
    req_valid = 1'b1;
    req_sel   = sel;
    req_dir   = dir;
    req_steps = 8'(steps);
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (c == 1) req_valid = 1'b0;
      exp_step = (steps > 0) && (c >= 5) && (c < 5 + 12 * steps) && (((c - 5) % 12) < 4);
      check($sformatf("%s.step@%0d", tag, c), pll_phasestep, exp_step);
      check($sformatf("%s.done@%0d", tag, c), done, (c == dc));
      check($sformatf("%s.busy@%0d", tag, c), busy, (c <= dc));
      check($sformatf("%s.ready@%0d", tag, c), req_ready, (c > dc));
      if (c <= dc) begin
        check($sformatf("%s.sel@%0d", tag, c), pll_phasesel, sel);
        check($sformatf("%s.dir@%0d", tag, c), pll_phasedir, dir);
      end
      if (pll_phasestep && !prev_step) pulses++;
      prev_step = pll_phasestep;
    end
    check({tag, ".pulses"}, pulses, steps);
    $display("txn %s: sel=%0d dir=%0d steps=%0d pulses=%0d done_at=T+%0d", tag, sel, dir, steps, pulses, dc);
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    req_valid  = 1'b0;
    req_sel    = 2'b00;
    req_dir    = 1'b0;
    req_steps  = 8'd0;
    tick();
    tick();
    check_all_zero("reset");
`ifdef PLL_PHASE_LOCKLOSS_CNT_EN
    check("reset.lockloss", lockloss_cnt, 0);
`endif
    $display("txn reset: outputs checked in reset");

    // Test 1: lock filter, cycle 0 = release with LOCK high.
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    for (int c = 1; c <= 17; c++) tick();
    check("lock.c17", lock_ok, 0);
    check("lock.ready_c17", req_ready, 0);
    tick();
    check("lock.c18", lock_ok, 1);
    check("lock.sysrst_c18", sys_rst_n, 1);
    check("lock.ready_c18", req_ready, 1);
    $display("txn lock: lock_ok=%0d sys_rst_n=%0d at cycle 18", lock_ok, sys_rst_n);

    // Tests 2-4: normal requests.
    run_req("one",   2'b10, 1'b1, 1, 19);
    run_req("three", 2'b01, 1'b0, 3, 43);
    run_req("zero",  2'b11, 1'b1, 0, 3);
    run_req("two",   2'b00, 1'b1, 2, 31);

    // Test 5: lock drops at T+17 (start of pulse 2) -> abort at T+21.
    check("abort.ready_T", req_ready, 1);
    req_valid = 1'b1;
    req_sel   = 2'b01;
    req_dir   = 1'b1;
    req_steps = 8'd3;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) req_valid = 1'b0;
      check($sformatf("abort.step@%0d", c), pll_phasestep,
            ((c >= 5 && c <= 8) || (c >= 17 && c <= 20)));
      check($sformatf("abort.aborted@%0d", c), aborted, (c == 21));
      check($sformatf("abort.done@%0d", c), done, 0);
      check($sformatf("abort.busy@%0d", c), busy, (c <= 21));
      check($sformatf("abort.lock@%0d", c), lock_ok, (c < 20));
      if (c == 17) pll_locked = 1'b0;
    end
    check("abort.ready_lost", req_ready, 0);
    check("abort.sysrst_lost", sys_rst_n, 0);
`ifdef PLL_PHASE_LOCKLOSS_CNT_EN
    check("abort.lockloss", lockloss_cnt, 1);
`endif
    pll_locked = 1'b1;
    for (int c = 1; c <= 17; c++) tick();
    check("relock.ready_r17", req_ready, 0);
    tick();
    check("relock.ready_r18", req_ready, 1);
    $display("txn abort: aborted at T+21, relocked ready=%0d", req_ready);

    // Test 6: async reset during HOLD of a 2-step request.
    req_valid = 1'b1;
    req_sel   = 2'b10;
    req_dir   = 1'b1;
    req_steps = 8'd2;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) req_valid = 1'b0;
    end
    check("hold.busy", busy, 1);
    check("hold.sel", pll_phasesel, 2'b10);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("asyncrst");
    #1;
    rst_n = 1'b1;
    for (int c = 1; c <= 17; c++) tick();
    check("postrst.busy", busy, 0);
    check("postrst.ready_c17", req_ready, 0);
    tick();
    check("postrst.ready_c18", req_ready, 1);
    $display("txn asyncrst: outputs cleared, relock ready=%0d", req_ready);
    run_req("after", 2'b11, 1'b0, 1, 19);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
